// File: rtl/id_pair_packer.sv
// Packs a stream of {ref_id, cmp_id} pairs into wide output words, padding the
// unused slots of the final word of each stream.
module id_pair_packer #(
    parameter int BUS_WIDTH    = 128,
    parameter int VEC_ID_WIDTH = 8,
    parameter logic [2*VEC_ID_WIDTH-1:0] PAD_VALUE = '1
) (
    input  logic                      ap_clk,
    input  logic                      ap_rstn,
    input  logic [2*VEC_ID_WIDTH-1:0] S_AXIS_ID_PAIR_tdata,
    input  logic                      S_AXIS_ID_PAIR_tvalid,
    input  logic                      S_AXIS_ID_PAIR_tlast,
    output logic                      S_AXIS_ID_PAIR_tready,
    output logic [BUS_WIDTH-1:0]      M_AXIS_DATA_tdata,
    output logic                      M_AXIS_DATA_tvalid,
    output logic                      M_AXIS_DATA_tlast,
    input  logic                      M_AXIS_DATA_tready,
    output logic [31:0]               stream_pairs,
    output logic                      stream_done
);

    localparam int PAIR_W = 2 * VEC_ID_WIDTH;
    localparam int SLOTS  = BUS_WIDTH / PAIR_W;
    localparam int CNT_W  = (SLOTS > 1) ? $clog2(SLOTS) : 1;
    localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(SLOTS - 1);
    localparam logic [BUS_WIDTH-1:0] PAD_WORD = {SLOTS{PAD_VALUE}};

    logic [CNT_W-1:0]     slot_cnt;
    logic [BUS_WIDTH-1:0] acc;
    logic [BUS_WIDTH-1:0] merged;
    logic [31:0]          pair_cnt;
    logic                 accept;
    logic                 complete;
    logic                 out_hs;

    assign S_AXIS_ID_PAIR_tready = !M_AXIS_DATA_tvalid || M_AXIS_DATA_tready;
    assign accept   = S_AXIS_ID_PAIR_tvalid && S_AXIS_ID_PAIR_tready;
    assign complete = accept && ((slot_cnt == LAST_SLOT) || S_AXIS_ID_PAIR_tlast);
    assign out_hs   = M_AXIS_DATA_tvalid && M_AXIS_DATA_tready;

    // Slots above slot_cnt always hold padding, so merging only the new pair
    // yields a correctly padded word on an early (tlast) completion.
    always_comb begin
        merged = acc;
        merged[int'(slot_cnt) * PAIR_W +: PAIR_W] = S_AXIS_ID_PAIR_tdata;
    end

    always_ff @(posedge ap_clk or negedge ap_rstn) begin
        if (!ap_rstn) begin
            slot_cnt <= '0;
            acc      <= PAD_WORD;
        end else if (complete) begin
            slot_cnt <= '0;
            acc      <= PAD_WORD;
        end else if (accept) begin
            slot_cnt <= slot_cnt + 1'b1;
            acc      <= merged;
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rstn) begin
        if (!ap_rstn) begin
            M_AXIS_DATA_tdata  <= '0;
            M_AXIS_DATA_tvalid <= 1'b0;
            M_AXIS_DATA_tlast  <= 1'b0;
        end else if (complete) begin
            M_AXIS_DATA_tdata  <= merged;
            M_AXIS_DATA_tvalid <= 1'b1;
            M_AXIS_DATA_tlast  <= S_AXIS_ID_PAIR_tlast;
        end else if (out_hs) begin
            M_AXIS_DATA_tvalid <= 1'b0;
            M_AXIS_DATA_tlast  <= 1'b0;
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rstn) begin
        if (!ap_rstn) begin
            pair_cnt     <= '0;
            stream_pairs <= '0;
            stream_done  <= 1'b0;
        end else begin
            stream_done <= out_hs && M_AXIS_DATA_tlast;
            if (accept) begin
                if (S_AXIS_ID_PAIR_tlast) begin
                    stream_pairs <= pair_cnt + 32'd1;
                    pair_cnt     <= '0;
                end else begin
                    pair_cnt <= pair_cnt + 32'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_id_pair_packer.sv
// Randomized scoreboard bench for id_pair_packer: a driver feeds pairs and a
// reference model; an independent monitor checks every accepted output word.
module tb_id_pair_packer;

    logic         clk;
    logic         rst_n;
    logic [15:0]  s_tdata;
    logic         s_tvalid;
    logic         s_tlast;
    logic         s_tready;
    logic [127:0] m_tdata;
    logic         m_tvalid;
    logic         m_tlast;
    logic         m_tready;
    logic [31:0]  stream_pairs;
    logic         stream_done;

    id_pair_packer dut (
        .ap_clk                (clk),
        .ap_rstn               (rst_n),
        .S_AXIS_ID_PAIR_tdata  (s_tdata),
        .S_AXIS_ID_PAIR_tvalid (s_tvalid),
        .S_AXIS_ID_PAIR_tlast  (s_tlast),
        .S_AXIS_ID_PAIR_tready (s_tready),
        .M_AXIS_DATA_tdata     (m_tdata),
        .M_AXIS_DATA_tvalid    (m_tvalid),
        .M_AXIS_DATA_tlast     (m_tlast),
        .M_AXIS_DATA_tready    (m_tready),
        .stream_pairs          (stream_pairs),
        .stream_done           (stream_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int errs   = 0;

    logic [16:0]  src_q[$];   // {tlast, data} waiting to be sent
    logic [15:0]  cur[$];     // pairs of the word being assembled
    int           model_cnt = 0;
    logic [127:0] exp_w[$];
    logic         exp_l[$];
    int           exp_sp[$];

    task automatic chk(input bit ok, input string name, input logic [127:0] act,
                       input logic [127:0] req);
        checks++;
        if (!ok) begin
            errs++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    function automatic logic [127:0] build_word();
        logic [127:0] w;
        for (int i = 0; i < 8; i++)
            w[i*16 +: 16] = (i < cur.size()) ? cur[i] : 16'hFFFF;
        return w;
    endfunction

    task automatic model_accept(input logic [15:0] d, input logic l);
        cur.push_back(d);
        model_cnt++;
        if (l) begin
            exp_sp.push_back(model_cnt);
            model_cnt = 0;
        end
        if (cur.size() == 8 || l) begin
            exp_w.push_back(build_word());
            exp_l.push_back(l);
            cur.delete();
        end
    endtask

    task automatic model_reset();
        cur.delete();
        model_cnt = 0;
        exp_w.delete();
        exp_l.delete();
        exp_sp.delete();
    endtask

    task automatic run(input int vduty, input int rduty, input int stall);
        int cyc = 0;
        bit hold = 0;
        logic [16:0] e = '0;
        while ((src_q.size() > 0 || hold) && cyc < 4000) begin
            @(negedge clk);
            if (!hold && src_q.size() > 0 && $urandom_range(99) < vduty) begin
                e = src_q.pop_front();
                hold = 1;
            end
            s_tvalid = hold;
            s_tdata  = e[15:0];
            s_tlast  = e[16] & hold;
            m_tready = (cyc < stall) ? 1'b0 : ($urandom_range(99) < rduty);
            #1;
            if (stall > 0 && cyc == stall - 1)
                chk(!s_tready, "stall_tready", {127'd0, s_tready}, 128'd0);
            if (hold && s_tready) begin
                model_accept(e[15:0], e[16]);
                hold = 0;
            end
            cyc++;
        end
        if (cyc >= 4000) chk(0, "run_timeout", 128'(cyc), 128'd4000);
        @(negedge clk);
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    task automatic drain();
        int cyc = 0;
        while (cyc < 300) begin
            @(negedge clk);
            m_tready = 1'b1;
            #3;
            if (exp_w.size() == 0 && !m_tvalid) break;
            cyc++;
        end
        if (cyc >= 300) chk(0, "drain_timeout", 128'(exp_w.size()), 128'd0);
        repeat (3) @(negedge clk);
    endtask

    // Monitor: pops the scoreboard on every output handshake.
    bit           pend_done  = 0;
    bit           stall_prev = 0;
    logic [127:0] prev_data  = '0;
    logic         prev_last  = 0;
    int           sp_exp;

    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (!rst_n) begin
                pend_done  = 0;
                stall_prev = 0;
                continue;
            end
            if (stream_done || pend_done) begin
                chk(stream_done == pend_done, "stream_done", {127'd0, stream_done},
                    {127'd0, pend_done});
                if (stream_done) begin
                    if (exp_sp.size() == 0) chk(0, "stream_pairs_unexpected", 128'(stream_pairs), 128'd0);
                    else begin
                        sp_exp = exp_sp.pop_front();
                        chk(stream_pairs == 32'(sp_exp), "stream_pairs", 128'(stream_pairs),
                            128'(sp_exp));
                    end
                end
            end
            if (stall_prev && m_tvalid)
                chk(m_tdata == prev_data && m_tlast == prev_last, "hold_stable", m_tdata, prev_data);
            pend_done = 0;
            if (m_tvalid && m_tready) begin
                if (exp_w.size() == 0) chk(0, "unexpected_word", m_tdata, 128'd0);
                else begin
                    chk(m_tdata == exp_w[0], "word_data", m_tdata, exp_w[0]);
                    chk(m_tlast == exp_l[0], "word_last", {127'd0, m_tlast}, {127'd0, exp_l[0]});
                    void'(exp_w.pop_front());
                    void'(exp_l.pop_front());
                end
                pend_done = m_tlast;
            end
            stall_prev = m_tvalid && !m_tready;
            prev_data  = m_tdata;
            prev_last  = m_tlast;
        end
    end

    initial begin
        rst_n    = 1'b0;
        s_tdata  = '0;
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        m_tready = 1'b0;
        #12;
        chk(s_tready == 1'b1, "rst_s_tready", {127'd0, s_tready}, 128'd1);
        chk(m_tvalid == 1'b0, "rst_m_tvalid", {127'd0, m_tvalid}, 128'd0);
        chk(m_tlast == 1'b0, "rst_m_tlast", {127'd0, m_tlast}, 128'd0);
        chk(m_tdata == '0, "rst_m_tdata", m_tdata, 128'd0);
        chk(stream_pairs == '0, "rst_stream_pairs", 128'(stream_pairs), 128'd0);
        chk(stream_done == 1'b0, "rst_stream_done", {127'd0, stream_done}, 128'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // 16 sequential pairs, two full words
        for (int i = 0; i < 16; i++) src_q.push_back({(i == 15), 16'h0100 + 16'(i)});
        run(100, 100, 0);
        drain();

        // short stream, padded word
        src_q.push_back({1'b0, 16'h0A0B});
        src_q.push_back({1'b0, 16'h0C0D});
        src_q.push_back({1'b1, 16'h0E0F});
        run(100, 100, 0);
        drain();

        // zero pair alone must differ from padding
        src_q.push_back({1'b1, 16'h0000});
        run(100, 100, 0);
        drain();

        // downstream stall with a full word pending
        for (int i = 0; i < 24; i++) src_q.push_back({(i == 23), 16'(i * 3 + 16'h2000)});
        run(100, 100, 20);
        drain();

        // sparse random upstream, random downstream, streams of 37
        for (int i = 0; i < 222; i++) src_q.push_back({((i + 1) % 37 == 0), 16'($urandom)});
        run(25, 50, 0);
        drain();

        // reset mid-stream discards the partial word
        for (int i = 0; i < 5; i++) src_q.push_back({1'b0, 16'h5500 + 16'(i)});
        run(100, 100, 0);
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk(stream_pairs == '0, "midrst_stream_pairs", 128'(stream_pairs), 128'd0);
        chk(m_tvalid == 1'b0, "midrst_m_tvalid", {127'd0, m_tvalid}, 128'd0);
        for (int i = 0; i < 8; i++) src_q.push_back({1'b0, 16'h7700 + 16'(i)});
        run(100, 100, 0);
        drain();
        chk(stream_pairs == '0, "post_rst_stream_pairs", 128'(stream_pairs), 128'd0);

        chk(exp_w.size() == 0, "words_left", 128'(exp_w.size()), 128'd0);
        chk(exp_sp.size() == 0, "streams_left", 128'(exp_sp.size()), 128'd0);
        $display("== %0d vectors applied, %0d miscompares ==", checks, errs);
        $finish;
    end

endmodule

// File: doc/id_pair_packer.md
ID_PAIR_PACKER -- requirements
Module: id_pair_packer

Interface
REQ-001 Parameter BUS_WIDTH, default 128, output word width in bits.
REQ-002 Parameter VEC_ID_WIDTH, default 8, width of one vector ID; one pair is 2*VEC_ID_WIDTH bits.
REQ-003 Parameter PAD_VALUE, default all ones (2*VEC_ID_WIDTH bits), filler for unused pair slots.
REQ-004 Derived: PAIR_W = 2*VEC_ID_WIDTH; SLOTS = BUS_WIDTH/PAIR_W (default 8); BUS_WIDTH is an integer multiple of PAIR_W.
REQ-005 ap_clk  in  1  single clock; all logic on rising edge.
REQ-006 ap_rstn  in  1  asynchronous, active-low reset.
REQ-007 S_AXIS_ID_PAIR_tdata  in  PAIR_W  ID pair, {ref_id, cmp_id}.
REQ-008 S_AXIS_ID_PAIR_tvalid  in  1  pair valid.
REQ-009 S_AXIS_ID_PAIR_tlast  in  1  final pair of a stream.
REQ-010 S_AXIS_ID_PAIR_tready  out  1  pair accepted when tvalid and tready both high.
REQ-011 M_AXIS_DATA_tdata  out  BUS_WIDTH  packed word.
REQ-012 M_AXIS_DATA_tvalid  out  1  word valid.
REQ-013 M_AXIS_DATA_tlast  out  1  last word of a stream.
REQ-014 M_AXIS_DATA_tready  in  1  downstream accepts word.
REQ-015 stream_pairs  out  32  number of pairs in most recently completed stream.
REQ-016 stream_done  out  1  one-cycle pulse when a tlast word is accepted downstream.

Function
REQ-017 Accumulator register of SLOTS pair slots plus slot counter (0..SLOTS-1); accepted pair k of a word is placed at bits [k*PAIR_W +: PAIR_W], slot 0 at LSBs.
REQ-018 S_AXIS_ID_PAIR_tready = !M_AXIS_DATA_tvalid || M_AXIS_DATA_tready (combinational); output holding register is free or draining this cycle.
REQ-019 Word completion = pair accepted while slot counter == SLOTS-1, or pair accepted with tlast=1.
REQ-020 On completion: next cycle M_AXIS_DATA_tdata = accumulator with new pair merged and all higher slots = PAD_VALUE, tvalid=1, tlast = input tlast; slot counter -> 0; accumulator slots -> PAD_VALUE.
REQ-021 Latency: completing pair accepted in cycle N -> word valid in cycle N+1.
REQ-022 Pair accepted without completion: stored in its slot, slot counter +1, no output change.
REQ-023 M_AXIS_DATA_tdata/tvalid/tlast are registers held stable while tvalid=1 and tready=0.
REQ-024 tvalid clears the cycle after a handshake unless a new completion occurs in the same cycle (back-to-back words allowed, e.g. SLOTS=1 equivalent or tlast-only word right after full word).
REQ-025 Input tvalid with tready=0: pair not consumed, no state change.
REQ-026 Pair counter (32-bit, wraps) increments per accepted pair; on accepted tlast pair, stream_pairs <= counter+1 and counter <= 0.
REQ-027 stream_done pulses for exactly one cycle on the output handshake of a word with tlast=1.
REQ-028 Throughput: one pair per cycle sustained while downstream tready=1.
REQ-029 No pair dropped, duplicated or reordered under any tvalid/tready pattern.

Reset
REQ-030 ap_rstn low, asynchronously: S_AXIS tready reflects tvalid=0 (i.e. 1 after reset), M_AXIS_DATA_tvalid=0, tlast=0, tdata=0, slot counter=0, accumulator slots=PAD_VALUE, pair counter=0, stream_pairs=0, stream_done=0.
REQ-031 Reset mid-stream discards partial accumulator and any pending output word; first pair after release goes to slot 0.

Verification
REQ-032 16 pairs 0x0100..0x010F, tlast on 16th, tready=1 -> two words, word0 = 0x0107_0106_..._0100, word1 tlast=1, stream_pairs=16, one stream_done pulse.
REQ-033 3 pairs 0x0A0B,0x0C0D,0x0E0F, tlast on 3rd -> one word 0xFFFF_FFFF_FFFF_FFFF_FFFF_0E0F_0C0D_0A0B, tlast=1, stream_pairs=3.
REQ-034 Pair 0x0000 as single tlast pair -> word with slot0=0x0000, slots1..7=0xFFFF; valid pair 0-0 distinguishable from padding.
REQ-035 Downstream tready low 20 cycles with full word pending, source tvalid=1 -> input tready=0, tdata stable, no pair lost; after release all 24 pairs delivered in order.
REQ-036 Random tvalid (25% duty, as sparse upstream traffic) and random tready over 200 pairs, tlast every 37th -> scoreboard matches, stream_pairs=37 per stream, padding only in tlast words.
REQ-037 ap_rstn asserted after 5 accepted pairs, then 8 new pairs -> first output word contains only the 8 new pairs, no tlast, stream_pairs=0.
